// File: rtl/sn76489_pkg.sv
// Shared types and constants for the SN76489 CPU write interface.
package sn76489_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RELEASE
  } state_t;

  typedef logic [2:0] reg_addr_t;

  localparam reg_addr_t TONE0 = 3'd0;
  localparam reg_addr_t VOL0  = 3'd1;
  localparam reg_addr_t TONE1 = 3'd2;
  localparam reg_addr_t VOL1  = 3'd3;
  localparam reg_addr_t TONE2 = 3'd4;
  localparam reg_addr_t VOL2  = 3'd5;
  localparam reg_addr_t NOISE = 3'd6;
  localparam reg_addr_t VOL3  = 3'd7;

  localparam logic [3:0] VOL_SILENT = 4'hF;
  localparam int unsigned CNT_W = 6;

  // A latch byte fills the low nibble of a tone period, a data byte the upper six bits.
  function automatic logic [9:0] tone_update(input logic [9:0] old,
                                             input logic       latch,
                                             input logic [5:0] data);
    return latch ? {old[9:4], data[3:0]} : {data, old[3:0]};
  endfunction

endpackage

// File: rtl/sn76489_wait_timer.sv
// Down-counter that holds the CPU for a fixed number of divided chip-clock pulses.
module sn76489_wait_timer
  import sn76489_pkg::*;
#(
  parameter int unsigned wait_cycles_g = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic active,
  input  logic clk_en,
  output logic expire
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(wait_cycles_g - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (active && clk_en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  // The pulse that finds the counter at zero is the last one of the wait.
  assign expire = active & clk_en & (count == '0);

endmodule

// File: rtl/sn76489_bus_ctrl.sv
// CPU write port of the SN76489: strobe edge detect, wait-state FSM and register file decode.
module sn76489_bus_ctrl
  import sn76489_pkg::*;
#(
  parameter int unsigned wait_cycles_g = 32
) (
  input  logic       clock_i,
  input  logic       res_n_i,
  input  logic       clk_en_i,
  input  logic       ce_n_i,
  input  logic       we_n_i,
  input  logic [7:0] d_i,
  output logic       ready_o,
  output logic [9:0] tone0_o,
  output logic [9:0] tone1_o,
  output logic [9:0] tone2_o,
  output logic [3:0] vol0_o,
  output logic [3:0] vol1_o,
  output logic [3:0] vol2_o,
  output logic [3:0] vol3_o,
  output logic [2:0] noise_ctrl_o,
  output logic       noise_rst_o
);

  state_t    state, state_nx;
  logic      wr, wr_q, accept, expire, latch;
  reg_addr_t last_reg, target;

  assign wr     = ~ce_n_i & ~we_n_i;
  assign accept = wr & ~wr_q & (state == ST_IDLE);
  assign latch  = d_i[7];
  assign target = latch ? d_i[6:4] : last_reg;

  // Driven straight from the state register so an asynchronous reset releases the CPU at once.
  assign ready_o = (state != ST_BUSY);

  sn76489_wait_timer #(
    .wait_cycles_g(wait_cycles_g)
  ) u_wait_timer (
    .clk   (clock_i),
    .rst_n (res_n_i),
    .load  (accept),
    .active(state == ST_BUSY),
    .clk_en(clk_en_i),
    .expire(expire)
  );

  always_ff @(posedge clock_i or negedge res_n_i) begin
    if (!res_n_i) begin
      state <= ST_IDLE;
      wr_q  <= 1'b0;
    end else begin
      state <= state_nx;
      wr_q  <= wr;
    end
  end

  // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (accept) state_nx = ST_BUSY;
      ST_BUSY:    if (expire) state_nx = wr ? ST_RELEASE : ST_IDLE;
      ST_RELEASE: if (!wr) state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge res_n_i) begin
    if (!res_n_i) begin
      last_reg     <= TONE0;
      tone0_o      <= '0;
      tone1_o      <= '0;
      tone2_o      <= '0;
      vol0_o       <= VOL_SILENT;
      vol1_o       <= VOL_SILENT;
      vol2_o       <= VOL_SILENT;
      vol3_o       <= VOL_SILENT;
      noise_ctrl_o <= '0;
      noise_rst_o  <= 1'b0;
    end else begin
      noise_rst_o <= 1'b0;
      if (accept) begin
        if (latch) last_reg <= d_i[6:4];
        case (target)
          TONE0: tone0_o <= tone_update(tone0_o, latch, d_i[5:0]);
          TONE1: tone1_o <= tone_update(tone1_o, latch, d_i[5:0]);
          TONE2: tone2_o <= tone_update(tone2_o, latch, d_i[5:0]);
          VOL0:  vol0_o  <= d_i[3:0];
          VOL1:  vol1_o  <= d_i[3:0];
          VOL2:  vol2_o  <= d_i[3:0];
          VOL3:  vol3_o  <= d_i[3:0];
          NOISE: begin
            noise_ctrl_o <= d_i[2:0];
            noise_rst_o  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
